// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the registered 16-bit ALU.
// Screens illegal/div-by-zero commands and returns results over valid/ready.
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int WFUN  = 4,
  parameter int WFLAG = 4,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  input  logic [WFUN-1:0]  CMD_FUN,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [WFUN-1:0]  ALU_FUN,
  input  logic [WIDTH-1:0] ALU_RESULT,
  input  logic [WFLAG-1:0] ALU_FLAGS,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic [WFLAG-1:0] RES_FLAGS,
  output logic             RES_ERR,
  output logic [CNTW-1:0]  OP_COUNT,
  output logic [7:0]       ERR_COUNT
);

  localparam logic [WFUN-1:0] FUN_NOP = '1;
  localparam logic [WFUN-1:0] FUN_DIV = WFUN'(3);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   err_q;
  logic   accept;
  logic   res_hs;
  logic   cmd_err;

  assign CMD_READY = (state_q == IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign res_hs    = RES_VALID && RES_READY;
  assign cmd_err   = (CMD_FUN == FUN_NOP) ||
                     ((CMD_FUN == FUN_DIV) && (CMD_B == '0));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  state_d = RESP;
      RESP:  if (res_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Rejected commands never reach the ALU: it sees a NOP on zero operands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q   <= 1'b0;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= FUN_NOP;
    end else if (accept) begin
      err_q   <= cmd_err;
      ALU_A   <= cmd_err ? '0 : CMD_A;
      ALU_B   <= cmd_err ? '0 : CMD_B;
      ALU_FUN <= cmd_err ? FUN_NOP : CMD_FUN;
    end else if (res_hs) begin
      ALU_FUN <= FUN_NOP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_FLAGS <= '0;
      RES_ERR   <= 1'b0;
    end else if (state_q == WAIT) begin
      RES_VALID <= 1'b1;
      RES_DATA  <= err_q ? '0 : ALU_RESULT;
      RES_FLAGS <= err_q ? '0 : ALU_FLAGS;
      RES_ERR   <= err_q;
    end else if (res_hs) begin
      RES_VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OP_COUNT  <= '0;
      ERR_COUNT <= '0;
    end else if (res_hs) begin
      OP_COUNT <= OP_COUNT + CNTW'(1);
      if (RES_ERR && (ERR_COUNT != 8'hFF))
        ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

endmodule
